// File: rtl/pio_in_edge_irq.sv
// Avalon-MM input PIO: synchronised WIDTH-bit input, per-bit edge capture (W1C)
// and a maskable level- or edge-driven interrupt.
module pio_in_edge_irq #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 0,
  parameter int unsigned IRQ_MODE    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam logic [2:0]  ArmMax = 3'(SYNC_STAGES + 1);
  localparam logic [31:0] WdMask = (WIDTH >= 32) ? 32'hFFFF_FFFF : ((32'h1 << WIDTH) - 32'h1);

  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic [WIDTH-1:0] raw_ev, ev, clr;
  logic [2:0]       arm_q, arm_d;
  logic [31:0]      rdata_d;
  logic             irq_d;
  logic             wr, armed;
  logic             unused_wd;

  assign wr        = chipselect & ~write_n;
  assign unused_wd = ^(writedata & ~WdMask);

  if (SYNC_STAGES == 0) begin : g_nosync
    assign s = in_port;
  end else begin : g_sync
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int unsigned k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
        sync_q[0] <= in_port;
        for (int unsigned k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
    end

    assign s = sync_q[SYNC_STAGES-1];
  end

  // Hold off edge detection until the reset-zero pipeline has flushed, so an
  // input idling high does not look like a rising edge after reset.
  assign armed = (arm_q == ArmMax);
  assign arm_d = armed ? arm_q : arm_q + 3'd1;

  always_comb begin
    if (EDGE_TYPE == 0)      raw_ev = s & ~prev_q;
    else if (EDGE_TYPE == 1) raw_ev = ~s & prev_q;
    else                     raw_ev = s ^ prev_q;
    ev = armed ? raw_ev : '0;
  end

  always_comb begin
    clr    = (wr && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    // A new event wins over a same-cycle clear of the same bit.
    edge_d = (edge_q & ~clr) | ev;
    mask_d = (wr && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
  end

  always_comb begin
    rdata_d = '0;
    unique case (address)
      2'd0:    rdata_d[WIDTH-1:0] = s;
      2'd1:    rdata_d = '0;
      2'd2:    rdata_d[WIDTH-1:0] = mask_q;
      default: rdata_d[WIDTH-1:0] = edge_q;
    endcase
  end

  assign irq_d = (IRQ_MODE != 0) ? |(edge_q & mask_q) : |(s & mask_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q   <= '0;
      mask_q   <= '0;
      edge_q   <= '0;
      arm_q    <= '0;
      readdata <= '0;
      irq      <= 1'b0;
    end else begin
      prev_q   <= s;
      mask_q   <= mask_d;
      edge_q   <= edge_d;
      arm_q    <= arm_d;
      readdata <= rdata_d;
      irq      <= irq_d;
    end
  end

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Four differently parameterised PIO instances on one shared bus, checked each
// cycle against a history-based reference model plus directed constant checks.
module tb_pio_in_edge_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        cs;
  logic        wn;
  logic [31:0] wd;
  logic [31:0] in_bus;
  logic [31:0] rd [4];
  logic        irqs [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // 0: W8 S2 rising edge-irq, 1: W8 S3 any edge-irq, 2: W8 S1 falling edge-irq,
  // 3: W32 S0 any level-irq
  pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs), .write_n(wn),
    .writedata(wd), .in_port(in_bus[7:0]), .readdata(rd[0]), .irq(irqs[0]));
  pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(3), .EDGE_TYPE(2), .IRQ_MODE(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs), .write_n(wn),
    .writedata(wd), .in_port(in_bus[7:0]), .readdata(rd[1]), .irq(irqs[1]));
  pio_in_edge_irq #(.WIDTH(8), .SYNC_STAGES(1), .EDGE_TYPE(1), .IRQ_MODE(1)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs), .write_n(wn),
    .writedata(wd), .in_port(in_bus[7:0]), .readdata(rd[2]), .irq(irqs[2]));
  pio_in_edge_irq #(.WIDTH(32), .SYNC_STAGES(0), .EDGE_TYPE(2), .IRQ_MODE(0)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs), .write_n(wn),
    .writedata(wd), .in_port(in_bus), .readdata(rd[3]), .irq(irqs[3]));

  function automatic int p_w(int i);
    return (i == 3) ? 32 : 8;
  endfunction
  function automatic int p_s(int i);
    case (i)
      0: return 2;
      1: return 3;
      2: return 1;
      default: return 0;
    endcase
  endfunction
  function automatic int p_e(int i);
    case (i)
      0: return 0;
      2: return 1;
      default: return 2;
    endcase
  endfunction
  function automatic int p_m(int i);
    return (i == 3) ? 0 : 1;
  endfunction
  function automatic logic [31:0] wmask(int i);
    return (p_w(i) == 32) ? 32'hFFFF_FFFF : ((32'h1 << p_w(i)) - 32'h1);
  endfunction

  // Model: hist[k-1] is the in_port value seen at clock edge k since reset.
  // The synchronised value at edge j is simply the input from SYNC_STAGES edges earlier.
  logic [31:0] hist [$];
  logic [31:0] m_mask [4];
  logic [31:0] m_edge [4];
  logic [31:0] m_rd [4];
  logic        m_irq [4];

  function automatic logic [31:0] hval(int idx);
    if (idx >= 1) return hist[idx-1];
    return 32'h0;
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < 4; i++) begin
      m_mask[i] = '0; m_edge[i] = '0; m_rd[i] = '0; m_irq[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    logic [31:0] s, pv, wm, ev, clr, rd_n;
    logic        irq_n;
    int          j;
    hist.push_back(in_bus);
    j = hist.size();
    for (int i = 0; i < 4; i++) begin
      wm = wmask(i);
      s  = hval(j - p_s(i)) & wm;
      pv = hval(j - 1 - p_s(i)) & wm;
      case (p_e(i))
        0:       ev = s & ~pv;
        1:       ev = ~s & pv & wm;
        default: ev = s ^ pv;
      endcase
      if (j - 1 < p_s(i) + 1) ev = '0;
      case (address)
        2'd0:    rd_n = s;
        2'd1:    rd_n = '0;
        2'd2:    rd_n = m_mask[i];
        default: rd_n = m_edge[i];
      endcase
      irq_n = (p_m(i) != 0) ? |(m_edge[i] & m_mask[i]) : |(s & m_mask[i]);
      clr = (cs && !wn && address == 2'd3) ? (wd & wm) : '0;
      m_edge[i] = (m_edge[i] & ~clr) | ev;
      if (cs && !wn && address == 2'd2) m_mask[i] = wd & wm;
      m_rd[i]  = rd_n;
      m_irq[i] = irq_n;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rd%0d@%0t", i, $time), rd[i], m_rd[i]);
      check($sformatf("irq%0d@%0t", i, $time), {31'b0, irqs[i]}, {31'b0, m_irq[i]});
    end
  endtask

  // Inputs change just after a falling edge; model advances at the rising edge.
  task automatic tick();
    @(posedge clk);
    if (reset_n) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address = a; wd = d; cs = 1'b1; wn = 1'b0;
    tick();
    cs = 1'b0; wn = 1'b1;
  endtask

  task automatic random_phase(input int n);
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(3) == 0) in_bus ^= ($urandom & $urandom & $urandom);
      address = 2'($urandom_range(3));
      cs = ($urandom_range(3) == 0);
      wn = ($urandom_range(1) == 0);
      wd = $urandom;
      tick();
    end
    cs = 1'b0; wn = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; in_bus = 32'hFF; address = 2'd0; cs = 1'b0; wn = 1'b1; wd = '0;
    model_reset();
    tick(); tick();
    reset_n = 1'b1;

    // Input idling high through reset: DATA shows it, no edge captured.
    repeat (6) tick();
    check("s1_data0", rd[0], 32'hFF);
    check("s1_data3", rd[3], 32'hFF);
    address = 2'd3;
    tick();
    check("s1_edgecap0", rd[0], 32'h0);
    check("s1_edgecap1", rd[1], 32'h0);
    check("s1_edgecap3", rd[3], 32'h0);

    // Rising capture latency and W1C on instance 0.
    in_bus = 32'h0;
    repeat (6) tick();
    bus_write(2'd3, 32'hFFFF_FFFF);
    bus_write(2'd2, 32'h1);
    address = 2'd3;
    in_bus[0] = 1'b1;
    repeat (3) tick();
    check("s2_irq_early", {31'b0, irqs[0]}, 32'h0);
    tick();
    check("s2_edgecap", rd[0], 32'h1);
    check("s2_irq", {31'b0, irqs[0]}, 32'h1);
    bus_write(2'd3, 32'h1);
    tick();
    check("s2_clr_edgecap", rd[0], 32'h0);
    check("s2_clr_irq", {31'b0, irqs[0]}, 32'h0);

    // Clear colliding with a new event on bit2: set wins; zero write clears nothing.
    in_bus[2] = 1'b1;
    tick(); tick();
    bus_write(2'd3, 32'h4);
    tick();
    check("s3_set_wins", rd[0] & 32'h4, 32'h4);
    bus_write(2'd3, 32'h0);
    tick();
    check("s3_w1c_zero", rd[0] & 32'h4, 32'h4);

    // Any-edge on instance 1: pulse of 3 clocks, cleared, recaptured on fall.
    repeat (6) tick();
    bus_write(2'd3, 32'hFFFF_FFFF);
    address = 2'd3;
    in_bus[5] = 1'b1;
    repeat (3) tick();
    in_bus[5] = 1'b0;
    tick(); tick();
    check("s4_rise", rd[1] & 32'h20, 32'h20);
    bus_write(2'd3, 32'h20);
    tick();
    check("s4_cleared", rd[1] & 32'h20, 32'h0);
    tick();
    check("s4_fall", rd[1] & 32'h20, 32'h20);

    // Level irq on instance 3.
    bus_write(2'd2, 32'h80);
    in_bus[7] = 1'b1;
    tick();
    check("s5_lvl_on", {31'b0, irqs[3]}, 32'h1);
    in_bus[7] = 1'b0;
    tick();
    check("s5_lvl_off", {31'b0, irqs[3]}, 32'h0);
    in_bus[7] = 1'b1;
    tick();
    bus_write(2'd2, 32'h0);
    tick();
    check("s5_mask_off", {31'b0, irqs[3]}, 32'h0);

    // Writes to DATA and the reserved slot change nothing.
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    address = 2'd2;
    tick();
    check("s6_mask_kept", rd[3], 32'h0);
    address = 2'd1;
    tick();
    check("s6_rsvd_zero", rd[0], 32'h0);

    random_phase(400);

    // Asynchronous reset in the middle of a cycle.
    bus_write(2'd2, 32'hFFFF_FFFF);
    in_bus = 32'hA5A5_5A5A;
    address = 2'd3;
    random_phase(8);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s6_rst_rd%0d", i), rd[i], 32'h0);
      check($sformatf("s6_rst_irq%0d", i), {31'b0, irqs[i]}, 32'h0);
    end
    tick(); tick();
    reset_n = 1'b1;
    repeat (6) tick();

    random_phase(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
